// File: rtl/timer_pkg.sv
// Shared definitions for the tune countdown timer: FSM encoding and BCD limits.
package timer_pkg;

  localparam int unsigned DIGIT_W      = 4;
  localparam int unsigned BCD_MAX      = 9;
  localparam int unsigned SEC_MAX_TENS = 5;
  localparam int unsigned MIN_MAX_TENS = 9;

  typedef enum logic [1:0] {
    SET  = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : timer_pkg

// File: rtl/bcd_field.sv
// Two-digit BCD up/down counter for one MM or SS field.
//   clock, reset     : clock, async active-high reset (clears to 00)
//   inc, dec         : one-cycle step requests (inc has priority)
//   ones, tens       : registered BCD digits
//   wrap_c           : combinational, high when this inc rolls max -> 00
//   borrow_c         : combinational, high when this dec rolls 00 -> max
module bcd_field
  import timer_pkg::*;
#(
  parameter int unsigned TENS_MAX = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               inc,
  input  logic               dec,
  output logic [DIGIT_W-1:0] ones,
  output logic [DIGIT_W-1:0] tens,
  output logic               wrap_c,
  output logic               borrow_c
);

  logic ones_max;
  logic tens_max;
  logic ones_zero;
  logic tens_zero;

  // Digit boundary detection shared by both directions
  always_comb begin
    ones_max  = (ones == DIGIT_W'(BCD_MAX));
    tens_max  = (tens == DIGIT_W'(TENS_MAX));
    ones_zero = (ones == '0);
    tens_zero = (tens == '0);
    wrap_c    = inc && ones_max && tens_max;
    borrow_c  = dec && !inc && ones_zero && tens_zero;
  end

  // Digit registers; the ones digit carries/borrows into tens inside the field
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ones <= '0;
      tens <= '0;
    end else if (inc) begin
      if (ones_max) begin
        ones <= '0;
        tens <= tens_max ? '0 : tens + DIGIT_W'(1);
      end else begin
        ones <= ones + DIGIT_W'(1);
      end
    end else if (dec) begin
      if (ones_zero) begin
        ones <= DIGIT_W'(BCD_MAX);
        tens <= tens_zero ? DIGIT_W'(TENS_MAX) : tens - DIGIT_W'(1);
      end else begin
        ones <= ones - DIGIT_W'(1);
      end
    end
  end

endmodule : bcd_field

// File: rtl/tune_countdown_timer.sv
// MM:SS tunable countdown timer.
//   clock, reset        : clock, async active-high reset
//   increment_signal    : one-cycle pulse, bumps the selected field while tuning
//   tunning             : level, requests set mode (aborts a running countdown)
//   field_sel           : 0 = seconds, 1 = minutes
//   start               : one-cycle pulse, starts countdown of a nonzero value
//   sec_ones..min_tens  : registered BCD digits for the display mux
//   running / expired   : registered status (RUN / DONE)
//   done                : one-cycle pulse in the cycle the digits reach 00:00
module tune_countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned PRESC_W = $clog2(CLK_HZ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               increment_signal,
  input  logic               tunning,
  input  logic               field_sel,
  input  logic               start,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] min_tens,
  output logic               running,
  output logic               expired,
  output logic               done
);

  state_t             state;
  logic [PRESC_W-1:0] presc;

  logic set_inc;
  logic sec_inc;
  logic min_inc;
  logic sec_dec;
  logic min_dec;
  logic tick;
  logic value_nz;
  logic last_sec;

  logic sec_wrap_c;
  logic sec_borrow_c;
  logic min_wrap_c;
  logic min_borrow_c;

  // Field enables. DONE accepts an increment in the same cycle it leaves for SET.
  always_comb begin
    set_inc  = increment_signal && tunning && ((state == SET) || (state == DONE));
    sec_inc  = set_inc && !field_sel;
    min_inc  = set_inc && field_sel;
    tick     = (state == RUN) && !tunning && (presc == PRESC_W'(CLK_HZ - 1));
    sec_dec  = tick;
    min_dec  = sec_borrow_c;
    value_nz = (sec_ones != '0) || (sec_tens != '0) ||
               (min_ones != '0) || (min_tens != '0);
    last_sec = (sec_ones == DIGIT_W'(1)) && (sec_tens == '0) &&
               (min_ones == '0) && (min_tens == '0);
  end

  bcd_field #(
    .TENS_MAX (SEC_MAX_TENS)
  ) u_sec (
    .clock    (clock),
    .reset    (reset),
    .inc      (sec_inc),
    .dec      (sec_dec),
    .ones     (sec_ones),
    .tens     (sec_tens),
    .wrap_c   (sec_wrap_c),
    .borrow_c (sec_borrow_c)
  );

  bcd_field #(
    .TENS_MAX (MIN_MAX_TENS)
  ) u_min (
    .clock    (clock),
    .reset    (reset),
    .inc      (min_inc),
    .dec      (min_dec),
    .ones     (min_ones),
    .tens     (min_tens),
    .wrap_c   (min_wrap_c),
    .borrow_c (min_borrow_c)
  );

  // Seconds wrap has no carry and minutes never borrow below 00:00
  logic unused_flags;
  assign unused_flags = ^{sec_wrap_c, min_wrap_c, min_borrow_c};

  // Mode FSM with prescaler and registered status outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= SET;
      presc   <= '0;
      running <= 1'b0;
      expired <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        SET: begin
          if (start && !tunning && value_nz) begin
            state   <= RUN;
            presc   <= '0;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (tunning) begin
            // Abort takes priority over a tick in the same cycle
            state   <= SET;
            presc   <= '0;
            running <= 1'b0;
          end else if (tick) begin
            presc <= '0;
            if (last_sec) begin
              state   <= DONE;
              running <= 1'b0;
              expired <= 1'b1;
              done    <= 1'b1;
            end
          end else begin
            presc <= presc + PRESC_W'(1);
          end
        end
        DONE: begin
          if (tunning) begin
            state   <= SET;
            expired <= 1'b0;
          end
        end
        default: begin
          state   <= SET;
          presc   <= '0;
          running <= 1'b0;
          expired <= 1'b0;
        end
      endcase
    end
  end

endmodule : tune_countdown_timer

// File: tb/tb_tune_countdown_timer.sv
// Directed + randomized bench for tune_countdown_timer against an MM:SS model.
module tb_tune_countdown_timer;

  localparam int unsigned CLK_HZ = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       increment_signal = 1'b0;
  logic       tunning = 1'b0;
  logic       field_sel = 1'b0;
  logic       start = 1'b0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       running, expired, done;

  tune_countdown_timer #(.CLK_HZ(CLK_HZ)) dut (
    .clock            (clock),
    .reset            (reset),
    .increment_signal (increment_signal),
    .tunning          (tunning),
    .field_sel        (field_sel),
    .start            (start),
    .sec_ones         (sec_ones),
    .sec_tens         (sec_tens),
    .min_ones         (min_ones),
    .min_tens         (min_tens),
    .running          (running),
    .expired          (expired),
    .done             (done)
  );

  always #5 clock = ~clock;

  // Reference model: mode 0=set 1=run 2=done; time held as plain integers
  int m_sec, m_min, m_presc, m_mode;
  bit m_done;
  int vectors = 0;
  int miscompares = 0;
  int done_seen = 0;

  function automatic logic [18:0] model_vec();
    return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10),
            m_mode == 1, m_mode == 2, m_done};
  endfunction

  task automatic check(input string tag);
    logic [18:0] obs, exp;
    obs = {min_tens, min_ones, sec_tens, sec_ones, running, expired, done};
    exp = model_vec();
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s got mm:ss=%h%h:%h%h run=%b exp=%b done=%b want vec=%h", tag,
             min_tens, min_ones, sec_tens, sec_ones, running, expired, done, exp);
    end
  endtask

  task automatic bump(input bit fs);
    if (fs) m_min = (m_min + 1) % 100;
    else    m_sec = (m_sec + 1) % 60;
  endtask

  // Apply one cycle of inputs, advance the model, check after the edge
  task automatic step(input bit inc, input bit tun, input bit fs, input bit st, input string tag);
    int total;
    increment_signal = inc; tunning = tun; field_sel = fs; start = st;
    m_done = 0;
    total = m_min * 60 + m_sec;
    case (m_mode)
      0: begin
        if (inc && tun) bump(fs);
        else if (st && !tun && total != 0) begin m_mode = 1; m_presc = 0; end
      end
      1: begin
        if (tun) begin m_mode = 0; m_presc = 0; end
        else if (m_presc == CLK_HZ - 1) begin
          m_presc = 0;
          total = total - 1;
          m_min = total / 60; m_sec = total % 60;
          if (total == 0) begin m_mode = 2; m_done = 1; end
        end else m_presc++;
      end
      default: begin
        if (tun) begin m_mode = 0; if (inc) bump(fs); end
      end
    endcase
    @(posedge clock); #1;
    if (done === 1'b1) done_seen++;
    check(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    increment_signal = 0; start = 0;
    m_sec = 0; m_min = 0; m_presc = 0; m_mode = 0; m_done = 0;
    #1;
    check(tag);
    @(posedge clock); #1;
    check(tag);
    reset = 1'b0;
  endtask

  // n increment pulses with random idle gaps
  task automatic press(input bit fs, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step(1, 1, fs, 0, tag);
      repeat ($urandom_range(0, 2)) step(0, 1, fs, 0, tag);
    end
  endtask

  initial begin
    #1;
    do_reset("reset");

    // 1: 61 seconds increments wrap to 01
    tunning = 1;
    press(0, 61, "t1_inc");
    assert ({sec_tens, sec_ones, min_tens, min_ones} === 16'h0100) else begin
      miscompares++; $error("FAIL t1_value got %h%h:%h%h want 00:01", min_tens, min_ones, sec_tens, sec_ones);
    end
    vectors++;

    // 2: 01:00 counts down to 00:00 in 240 cycles with a single done pulse
    do_reset("t2_reset");
    press(1, 1, "t2_set");
    step(0, 0, 0, 0, "t2_idle");
    done_seen = 0;
    step(0, 0, 0, 1, "t2_start");
    for (int i = 0; i < 240; i++) step(0, 0, 0, 0, "t2_run");
    assert (done === 1'b1 && expired === 1'b1) else begin
      miscompares++; $error("FAIL t2_done got done=%b expired=%b want 1 1", done, expired);
    end
    vectors++;
    for (int i = 0; i < 6; i++) step(0, 0, 0, i == 2, "t2_hold");
    assert (done_seen == 1) else begin
      miscompares++; $error("FAIL t2_pulses got %0d want 1", done_seen);
    end
    vectors++;
    step(1, 1, 0, 0, "t2_exit_inc");

    // 3: start at 00:00 is ignored
    do_reset("t3_reset");
    step(0, 0, 0, 1, "t3_start");
    step(0, 0, 0, 0, "t3_idle");

    // 4: abort mid-run holds the value, then tuning resumes
    do_reset("t4_reset");
    press(0, 3, "t4_set");
    step(0, 0, 0, 1, "t4_start");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, "t4_run");
    step(0, 1, 0, 0, "t4_abort");
    press(0, 2, "t4_inc");

    // 5: minutes wrap 99 -> 00, run ignores start and increment
    do_reset("t5_reset");
    press(0, 7, "t5_sec");
    press(1, 100, "t5_min");
    step(0, 0, 0, 1, "t5_start");
    for (int i = 0; i < 12; i++) step(i % 2 == 0, 0, 1, i % 3 == 0, "t5_run");

    // 6: reset mid-countdown clears with no done pulse
    do_reset("t6_reset");
    press(0, 10, "t6_set");
    done_seen = 0;
    step(0, 0, 0, 1, "t6_start");
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, "t6_run");
    do_reset("t6_midreset");
    step(0, 0, 0, 0, "t6_after");
    assert (done_seen == 0) else begin
      miscompares++; $error("FAIL t6_nodone got %0d pulses want 0", done_seen);
    end
    vectors++;

    // Random mixed traffic, biased toward long runs
    for (int i = 0; i < 600; i++) begin
      bit tun;
      tun = ($urandom_range(0, 19) == 0) ? 1'b1 : (m_mode == 0 ? $urandom_range(0, 1) == 1 : 1'b0);
      step($urandom_range(0, 2) == 0, tun, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_tune_countdown_timer
